// File: rtl/bloons_pkg.sv
// rtl/bloons_pkg.sv - shared sizes, types and scanner states for the bloon hit scanner
package bloons_pkg;
  localparam int NUM_PROJ  = 8;
  localparam int NUM_BLOON = 32;
  localparam int COORD_W   = 10;
  localparam int HIT_R     = 8;

  localparam int PROJ_W  = $clog2(NUM_PROJ);
  localparam int BLOON_W = $clog2(NUM_BLOON);
  localparam int IDX_W   = PROJ_W + BLOON_W;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [NUM_BLOON-1:0] bloon_mask_t;

  typedef enum logic [2:0] {IDLE, SNAP, SCAN, DRAIN, PUBLISH} scan_state_t;

  // Zero-extended subtract so coordinates at 0 and full scale never wrap.
  function automatic logic [COORD_W:0] abs_diff(input coord_t a, input coord_t b);
    logic [COORD_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[COORD_W] ? (~d + 1'b1) : d;
  endfunction
endpackage

// File: rtl/hit_box_cmp.sv
// rtl/hit_box_cmp.sv - two-stage registered |dx|/|dy| square hit-box compare
module hit_box_cmp
  import bloons_pkg::*;
(
  input  logic               Clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] proj_x,
  input  logic [COORD_W-1:0] proj_y,
  input  logic [COORD_W-1:0] bloon_x,
  input  logic [COORD_W-1:0] bloon_y,
  input  logic               pair_live,
  input  logic [PROJ_W-1:0]  in_p,
  input  logic [BLOON_W-1:0] in_b,
  output logic               out_valid,
  output logic               hit,
  output logic [PROJ_W-1:0]  out_p,
  output logic [BLOON_W-1:0] out_b
);
  localparam logic [COORD_W:0] HIT_LIM = (COORD_W+1)'(HIT_R);

  logic               s1_valid;
  logic               s1_pv;
  logic [COORD_W:0]   s1_adx;
  logic [COORD_W:0]   s1_ady;
  logic [PROJ_W-1:0]  s1_p;
  logic [BLOON_W-1:0] s1_b;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_pv     <= 1'b0;
      s1_adx    <= '0;
      s1_ady    <= '0;
      s1_p      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      hit       <= 1'b0;
      out_p     <= '0;
      out_b     <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_pv     <= pair_live;
      s1_adx    <= abs_diff(proj_x, bloon_x);
      s1_ady    <= abs_diff(proj_y, bloon_y);
      s1_p      <= in_p;
      s1_b      <= in_b;
      out_valid <= s1_valid;
      hit       <= s1_pv & (s1_adx <= HIT_LIM) & (s1_ady <= HIT_LIM);
      out_p     <= s1_p;
      out_b     <= s1_b;
    end
  end
endmodule

// File: rtl/bloon_hit_scanner.sv
// rtl/bloon_hit_scanner.sv - per-frame projectile/bloon collision scan producing hit masks
module bloon_hit_scanner
  import bloons_pkg::*;
(
  input  logic                            Clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [NUM_PROJ*COORD_W-1:0]     proj_x,
  input  logic [NUM_PROJ*COORD_W-1:0]     proj_y,
  input  logic [NUM_PROJ-1:0]             proj_active,
  input  logic [NUM_BLOON*COORD_W-1:0]    bloon_x,
  input  logic [NUM_BLOON*COORD_W-1:0]    bloon_y,
  input  logic [NUM_BLOON-1:0]            bloon_live,
  output logic [NUM_PROJ*NUM_BLOON-1:0]   hit_mask,
  output logic                            done,
  output logic                            busy,
  output logic                            overrun
);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  scan_state_t state, next_state;

  coord_t [NUM_PROJ-1:0]       snap_px, snap_py;
  coord_t [NUM_BLOON-1:0]      snap_bx, snap_by;
  logic [NUM_PROJ-1:0]         snap_act;
  bloon_mask_t                 snap_live;
  bloon_mask_t [NUM_PROJ-1:0]  work;
  bloon_mask_t [NUM_PROJ-1:0]  pub;
  logic [IDX_W-1:0]            idx;
  logic                        drain_last;

  logic [PROJ_W-1:0]  cur_p;
  logic [BLOON_W-1:0] cur_b;
  logic               res_valid, res_hit;
  logic [PROJ_W-1:0]  res_p;
  logic [BLOON_W-1:0] res_b;

  assign cur_p    = idx[IDX_W-1:BLOON_W];
  assign cur_b    = idx[BLOON_W-1:0];
  assign hit_mask = pub;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SNAP;
      SNAP:    next_state = SCAN;
      SCAN:    if (idx == IDX_LAST) next_state = DRAIN;
      DRAIN:   if (drain_last) next_state = PUBLISH;
      PUBLISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  hit_box_cmp u_cmp (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .in_valid  (state == SCAN),
    .proj_x    (snap_px[cur_p]),
    .proj_y    (snap_py[cur_p]),
    .bloon_x   (snap_bx[cur_b]),
    .bloon_y   (snap_by[cur_b]),
    .pair_live (snap_act[cur_p] & snap_live[cur_b]),
    .in_p      (cur_p),
    .in_b      (cur_b),
    .out_valid (res_valid),
    .hit       (res_hit),
    .out_p     (res_p),
    .out_b     (res_b)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_px    <= '0;
      snap_py    <= '0;
      snap_bx    <= '0;
      snap_by    <= '0;
      snap_act   <= '0;
      snap_live  <= '0;
      work       <= '0;
      pub        <= '0;
      idx        <= '0;
      drain_last <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done       <= (state == PUBLISH);
      busy       <= (next_state != IDLE);
      overrun    <= start && (state != IDLE);
      drain_last <= (state == DRAIN) ? ~drain_last : 1'b0;
      if (state == SNAP) begin
        snap_px   <= proj_x;
        snap_py   <= proj_y;
        snap_bx   <= bloon_x;
        snap_by   <= bloon_y;
        snap_act  <= proj_active;
        snap_live <= bloon_live;
        work      <= '0;
        idx       <= '0;
      end
      if (state == SCAN) idx <= idx + 1'b1;
      // Results land two cycles behind issue; DRAIN covers the tail.
      if (res_valid) work[res_p][res_b] <= res_hit;
      if (state == PUBLISH) pub <= work;
    end
  end
endmodule

// File: tb/tb_bloon_hit_scanner.sv
// tb/tb_bloon_hit_scanner.sv - randomized self-checking bench for bloon_hit_scanner
module tb_bloon_hit_scanner;
  logic         Clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [79:0]  proj_x, proj_y;
  logic [7:0]   proj_active;
  logic [319:0] bloon_x, bloon_y;
  logic [31:0]  bloon_live;
  logic [255:0] hit_mask;
  logic         done, busy, overrun;

  logic [9:0] px [8];
  logic [9:0] py [8];
  logic [9:0] bx [32];
  logic [9:0] by [32];
  logic [7:0]  pact;
  logic [31:0] blive;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    proj_x = '0; proj_y = '0; bloon_x = '0; bloon_y = '0;
    for (int i = 0; i < 8; i++) begin
      proj_x[i*10 +: 10] = px[i];
      proj_y[i*10 +: 10] = py[i];
    end
    for (int i = 0; i < 32; i++) begin
      bloon_x[i*10 +: 10] = bx[i];
      bloon_y[i*10 +: 10] = by[i];
    end
    proj_active = pact;
    bloon_live  = blive;
  end

  bloon_hit_scanner dut (
    .Clk(Clk), .reset_n(reset_n), .start(start),
    .proj_x(proj_x), .proj_y(proj_y), .proj_active(proj_active),
    .bloon_x(bloon_x), .bloon_y(bloon_y), .bloon_live(bloon_live),
    .hit_mask(hit_mask), .done(done), .busy(busy), .overrun(overrun)
  );

  function automatic logic [255:0] model();
    logic [255:0] m = '0;
    for (int p = 0; p < 8; p++)
      for (int b = 0; b < 32; b++) begin
        int dx = int'(px[p]) - int'(bx[b]);
        int dy = int'(py[p]) - int'(by[b]);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        m[p*32 + b] = pact[p] & blive[b] & (dx <= 8) & (dy <= 8);
      end
    return m;
  endfunction

  task automatic set_far();
    for (int i = 0; i < 8; i++) begin px[i] = 10'd300; py[i] = 10'd300; end
    for (int i = 0; i < 32; i++) begin bx[i] = 10'd600; by[i] = 10'd600; end
    pact = '0;
    blive = '1;
  endtask

  task automatic set_random(input int span);
    for (int i = 0; i < 8; i++) begin
      px[i] = 10'($urandom_range(0, span)); py[i] = 10'($urandom_range(0, span));
    end
    for (int i = 0; i < 32; i++) begin
      bx[i] = 10'($urandom_range(0, span)); by[i] = 10'($urandom_range(0, span));
    end
    pact  = 8'($urandom);
    blive = $urandom;
  endtask

  // Starts a scan and counts edges from the start-sampling edge until done.
  task automatic run_scan(input int pulse_at, input bit mutate, output int lat, output int novr);
    @(negedge Clk); start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    lat = 0; novr = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge Clk); #1;
      if (mutate && c == 1) begin
        set_far();
        blive[17] = 1'b0;
      end
      start = (c == pulse_at);
      if (overrun) novr++;
      if (done) begin lat = c; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    set_far();
    reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (hit_mask !== '0) begin errors++; $display("FAIL reset_mask got %h want 0", hit_mask); end
    checks++; if ({done, busy, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {done, busy, overrun}); end
    @(negedge Clk); reset_n = 1'b1;
    @(negedge Clk);
    checks++; if ({done, busy, overrun} !== 3'b000) begin errors++; $display("FAIL idle_flags got %b want 000", {done, busy, overrun}); end
  endtask

  task automatic test_empty();
    int lat, novr;
    set_random(1023);
    pact = '0;
    run_scan(0, 0, lat, novr);
    checks++; if (lat !== 260) begin errors++; $display("FAIL empty_latency got %0d want 260", lat); end
    checks++; if (hit_mask !== '0) begin errors++; $display("FAIL empty_mask got %h want 0", hit_mask); end
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy got %b want 0", busy); end
  endtask

  task automatic test_directed();
    int lat, novr;
    logic [255:0] exp;
    set_far();
    pact[3] = 1'b1; px[3] = 10'd100; py[3] = 10'd100;
    bx[17] = 10'd108; by[17] = 10'd92;
    exp = model();
    run_scan(0, 0, lat, novr);
    checks++; if (hit_mask[3*32 +: 32] !== 32'h0002_0000) begin errors++; $display("FAIL inclusive_word3 got %h want 00020000", hit_mask[3*32 +: 32]); end
    checks++; if (hit_mask !== exp) begin errors++; $display("FAIL inclusive_mask got %h want %h", hit_mask, exp); end
    bx[17] = 10'd109; by[17] = 10'd100;
    run_scan(0, 0, lat, novr);
    checks++; if (hit_mask !== '0) begin errors++; $display("FAIL just_outside got %h want 0", hit_mask); end
  endtask

  task automatic test_dead_and_snapshot();
    int lat, novr;
    logic [255:0] exp;
    set_far();
    pact[3] = 1'b1; px[3] = 10'd100; py[3] = 10'd100;
    bx[17] = 10'd108; by[17] = 10'd92;
    blive[17] = 1'b0;
    run_scan(0, 0, lat, novr);
    checks++; if (hit_mask !== '0) begin errors++; $display("FAIL dead_bloon got %h want 0", hit_mask); end
    blive[17] = 1'b1;
    exp = model();
    run_scan(0, 1, lat, novr);
    checks++; if (hit_mask !== exp || exp[3*32 + 17] !== 1'b1) begin errors++; $display("FAIL snapshot got %h want %h", hit_mask, exp); end
  endtask

  task automatic test_edges();
    int lat, novr;
    logic [255:0] exp;
    set_far();
    for (int i = 0; i < 32; i++) begin bx[i] = 10'd512; by[i] = 10'd512; end
    pact[1:0] = 2'b11;
    px[0] = 10'd0;    py[0] = 10'd0;    bx[0] = 10'd1023; by[0] = 10'd1023;
    px[1] = 10'd1023; py[1] = 10'd0;    bx[1] = 10'd1016; by[1] = 10'd8;
    exp = model();
    run_scan(0, 0, lat, novr);
    checks++; if (hit_mask[0] !== 1'b0) begin errors++; $display("FAIL edge_nowrap got %b want 0", hit_mask[0]); end
    checks++; if (hit_mask[32 + 1] !== 1'b1) begin errors++; $display("FAIL edge_hit got %b want 1", hit_mask[33]); end
    checks++; if (hit_mask !== exp) begin errors++; $display("FAIL edge_mask got %h want %h", hit_mask, exp); end
  endtask

  task automatic test_random();
    int lat, novr;
    logic [255:0] exp;
    for (int it = 0; it < 6; it++) begin
      set_random((it % 2) ? 40 : 120);
      exp = model();
      run_scan(0, 0, lat, novr);
      checks++; if (hit_mask !== exp || lat !== 260) begin errors++; $display("FAIL random_%0d lat %0d mask %h want %h", it, lat, hit_mask, exp); end
    end
  endtask

  task automatic test_overrun();
    int lat, novr;
    logic [255:0] exp;
    set_random(40);
    exp = model();
    run_scan(50, 0, lat, novr);
    checks++; if (novr !== 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", novr); end
    checks++; if (lat !== 260) begin errors++; $display("FAIL overrun_latency got %0d want 260", lat); end
    checks++; if (hit_mask !== exp) begin errors++; $display("FAIL overrun_mask got %h want %h", hit_mask, exp); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, novr, seen_done;
    logic [255:0] exp;
    set_random(40);
    pact = '1; blive = '1;
    exp = model();
    run_scan(0, 0, lat, novr);
    checks++; if (hit_mask !== exp || exp === '0) begin errors++; $display("FAIL prereset_mask got %h want %h", hit_mask, exp); end
    @(negedge Clk); start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    seen_done = 0;
    for (int c = 1; c < 120; c++) begin @(posedge Clk); #1; if (done) seen_done++; end
    reset_n = 1'b0;
    #1;
    checks++; if (hit_mask !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_clear mask %h busy %b want 0 0", hit_mask, busy); end
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
    for (int c = 0; c < 300; c++) begin @(posedge Clk); #1; if (done) seen_done++; end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", seen_done); end
    run_scan(0, 0, lat, novr);
    checks++; if (hit_mask !== exp || lat !== 260) begin errors++; $display("FAIL postreset lat %0d mask %h want %h", lat, hit_mask, exp); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, ndone;
    logic [255:0] exp;
    set_random(40);
    exp = model();
    t1 = 0; t2 = 0; ndone = 0;
    @(negedge Clk); start = 1'b1;
    for (int c = 1; c <= 700 && ndone < 2; c++) begin
      @(posedge Clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) t1 = c; else t2 = c;
        checks++; if (hit_mask !== exp) begin errors++; $display("FAIL b2b_mask_%0d got %h want %h", ndone, hit_mask, exp); end
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 2 || t2 - t1 !== 261) begin errors++; $display("FAIL b2b_gap got %0d dones gap %0d want 2 gap 261", ndone, t2 - t1); end
    repeat (5) @(posedge Clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_directed();
    test_dead_and_snapshot();
    test_edges();
    test_random();
    test_overrun();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bloon_hit_scanner.md
Name: bloon_hit_scanner

Overview:
- Per-frame collision generator and the producer side of the per-projectile hit-mask interface.
- Emits hit_mask[p][b] = 1 when projectile p overlaps live bloon b. The sticky dead-bloon tracker consumes these masks as its 8×32 input.
- Time-multiplexes one projectile/bloon pair test per clock, so one comparator is shared across all 256 pairs.
- Started once per frame by the video vsync pulse. Publishes a complete, glitch-free mask set at the end of each scan.

Parameters:
- NUM_PROJ, 8, number of projectile slots.
- NUM_BLOON, 32, number of bloon slots.
- COORD_W, 10, width of each x/y screen coordinate.
- HIT_R, 8, half-size in pixels of the square hit box.

Ports:
- Clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame-start pulse; sampled only in IDLE.
- proj_x  in  NUM_PROJ×COORD_W  projectile x positions.
- proj_y  in  NUM_PROJ×COORD_W  projectile y positions.
- proj_active  in  NUM_PROJ  projectile slot valid.
- bloon_x  in  NUM_BLOON×COORD_W  bloon x positions.
- bloon_y  in  NUM_BLOON×COORD_W  bloon y positions.
- bloon_live  in  NUM_BLOON  bloon slot live (not dead, spawned).
- hit_mask  out  NUM_PROJ×NUM_BLOON  published masks, one NUM_BLOON-bit word per projectile.
- done  out  1  one-cycle pulse; hit_mask updated on this same edge.
- busy  out  1  high from SNAP through PUBLISH.
- overrun  out  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - hit_mask, working mask, snapshot registers, and counters all cleared to 0.
  - done=0, busy=0, overrun=0.
- IDLE: start=1 → SNAP. Otherwise hold. hit_mask holds its last published value.
- SNAP (1 cycle):
  - Captures all positions, proj_active and bloon_live into snapshot registers.
  - Clears the working mask; pair index idx=0. → SCAN.
  - Inputs may change freely after this edge.
- SCAN (NUM_PROJ×NUM_BLOON cycles): each cycle issues pair idx, with p=idx/NUM_BLOON and b=idx%NUM_BLOON.
  - Stage 1 (registered): adx=|proj_x[p]−bloon_x[b]|, ady=|proj_y[p]−bloon_y[b]|, computed at COORD_W+1 bits with the subtraction unsigned-extended. Also registers pv=proj_active[p]&bloon_live[b], plus p and b.
  - Stage 2 (registered): work[p][b] <= pv & (adx<=HIT_R) & (ady<=HIT_R).
  - idx increments each cycle. The last index → DRAIN.
- DRAIN (2 cycles): flushes stage 1 and stage 2. → PUBLISH.
- PUBLISH (1 cycle): hit_mask <= work, done=1. → IDLE.
- Latency:
  - done is high on cycle NUM_PROJ×NUM_BLOON+4 after the start-sampling edge (260 with defaults).
  - The next start is accepted in the cycle after done.
- Hit semantics:
  - The box test is inclusive: a distance of exactly HIT_R is a hit.
  - One bloon may set bits in several projectile words.
  - Inactive projectiles produce all-zero words. Dead bloons produce zero columns.
- Boundaries:
  - Coordinates 0 and 2^COORD_W−1 must not wrap; the widened subtract guarantees this.
  - start while busy: ignored, overrun pulses once per offending start, and the scan is unaffected.
  - start held high continuously: a new scan begins each time IDLE is re-entered.
  - reset_n low mid-scan: immediate return to IDLE with hit_mask cleared. No done is issued.
- Outputs are registered only; nothing combinational reaches hit_mask or done.

Decomposition:
- Shared package bloons_pkg:
  - NUM_PROJ, NUM_BLOON, COORD_W, HIT_R.
  - coord_t typedef.
  - bloon_mask_t typedef (logic [NUM_BLOON-1:0]).
  - Scanner state enum {IDLE, SNAP, SCAN, DRAIN, PUBLISH}.
- One sub-module, hit_box_cmp: the registered two-stage |dx|/|dy| compare pipeline with valid passthrough. The top holds the FSM, snapshot, index counter and mask registers.

Test Plan:
- Reset then one start; all proj_active=0 → done exactly 260 cycles later, hit_mask all 0, busy low afterwards.
- Proj 3 at (100,100) active; bloon 17 at (108,92) live; all else far away → hit_mask[3]=32'h0002_0000 only. Repeat with bloon 17 at (109,100) → all zero.
- Same geometry with bloon_live[17]=0 → zero. Also change the positions 1 cycle after start → result reflects the snapshot values only.
- Edge coordinates: proj at (0,0), bloon at (1023,1023), and proj at (1023,0) with bloon at (1016,8) → first pair no hit (no wrap), second pair hit.
- Second start pulsed at cycle 50 of a scan → overrun single pulse, done still at cycle 260, mask correct.
- reset_n dropped at cycle 120 of a scan in which hits were expected → hit_mask=0, no done. A fresh start afterwards gives the correct masks.
